// File: rtl/mux2_rr_arbiter_if.sv
// Handshake bundle between two requesters, the shared-mux consumer and the arbiter.
// The master side drives requests/data/out_ready; the slave side is the arbiter.
interface mux2_rr_arbiter_if #(
  parameter int WIDTH     = 1,
  parameter int MAX_BURST = 4
);
  localparam int CNT_W = $clog2(MAX_BURST) + 1;

  // Valid/ready semantics:
  // - req_X/data_X is held by requester X until ack_X is seen high at a clock edge.
  // - out_data is taken when out_valid & out_ready are both high at a clock edge.
  logic             req_a;
  logic [WIDTH-1:0] data_a;
  logic             ack_a;
  logic             req_b;
  logic [WIDTH-1:0] data_b;
  logic             ack_b;
  logic             sel;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic             busy;
  logic [1:0]       state;
  logic [CNT_W-1:0] burst_cnt;

  modport master (
    output req_a, data_a, req_b, data_b, out_ready,
    input  ack_a, ack_b, sel, out_valid, out_data, busy, state, burst_cnt
  );

  modport slave (
    input  req_a, data_a, req_b, data_b, out_ready,
    output ack_a, ack_b, sel, out_valid, out_data, busy, state, burst_cnt
  );
endinterface

// File: rtl/mux2_rr_arbiter.sv
// Round-robin, burst-limited arbiter that steers A or B through the shared 2:1 mux
// into a one-entry registered output stage.
module mux2_rr_arbiter #(
  parameter int WIDTH     = 1,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  mux2_rr_arbiter_if.slave  bus
);
  localparam int CNT_W = $clog2(MAX_BURST) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GNT_A = 2'd1;
  localparam logic [1:0] GNT_B = 2'd2;

  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             last_q;   // 1 = B was served last, so A wins the next tie
  logic             sel_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic             space;
  logic             ack_a;
  logic             ack_b;
  logic             burst_end;

  assign space     = ~out_valid_q | bus.out_ready;
  assign ack_a     = (state_q == GNT_A) & bus.req_a & space;
  assign ack_b     = (state_q == GNT_B) & bus.req_b & space;
  assign burst_end = (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.req_a && bus.req_b) state_d = last_q ? GNT_A : GNT_B;
        else if (bus.req_a)         state_d = GNT_A;
        else if (bus.req_b)         state_d = GNT_B;
      end
      GNT_A: begin
        if (!bus.req_a) begin
          state_d = bus.req_b ? GNT_B : IDLE;
          cnt_d   = '0;
        end else if (ack_a) begin
          if (burst_end) begin
            cnt_d = '0;
            if (bus.req_b) state_d = GNT_B;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      GNT_B: begin
        if (!bus.req_b) begin
          state_d = bus.req_a ? GNT_A : IDLE;
          cnt_d   = '0;
        end else if (ack_b) begin
          if (burst_end) begin
            cnt_d = '0;
            if (bus.req_a) state_d = GNT_A;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // sel tracks the next state so it flips on the same edge as a direct A<->B switch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sel_q   <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= (state_d == GNT_B);
      if (ack_a)      last_q <= 1'b0;
      else if (ack_b) last_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (ack_a) begin
      out_valid_q <= 1'b1;
      out_data_q  <= bus.data_a;
    end else if (ack_b) begin
      out_valid_q <= 1'b1;
      out_data_q  <= bus.data_b;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.ack_a     = ack_a;
  assign bus.ack_b     = ack_b;
  assign bus.sel       = sel_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.state     = state_q;
  assign bus.burst_cnt = cnt_q;
endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Directed bench for mux2_rr_arbiter: a per-cycle vector table plus hand-written
// sequences for the mux truth table and mid-burst asynchronous reset.
module tb_mux2_rr_arbiter;
  localparam int WIDTH     = 1;
  localparam int MAX_BURST = 4;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  mux2_rr_arbiter_if #(.WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) bus ();

  mux2_rr_arbiter #(.WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: run exceeded time limit (actual=running required=finished)");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic ra, rb, da, db, rdy;
    logic e_ack_a, e_ack_b, e_sel, e_busy, e_ov, e_od;
  } vec_t;

  vec_t             vecs[$];
  logic [WIDTH-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic ra, rb, da, db, rdy,
                     input logic aa, ab, s, bz, ov, od);
    vec_t v;
    v.ra = ra; v.rb = rb; v.da = da; v.db = db; v.rdy = rdy;
    v.e_ack_a = aa; v.e_ack_b = ab; v.e_sel = s; v.e_busy = bz; v.e_ov = ov; v.e_od = od;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic ra, rb, da, db, rdy);
    bus.req_a     = ra;
    bus.req_b     = rb;
    bus.data_a    = da;
    bus.data_b    = db;
    bus.out_ready = rdy;
  endtask

  initial begin
    logic [7:0]       seen;
    logic             exp_c;
    logic             a_bit;
    logic             b_bit;
    logic [WIDTH-1:0] exp_d;
    checks = 0;
    errors = 0;
    seen   = '0;

    // ra rb da db rdy | ack_a ack_b sel busy out_valid out_data
    // single requester A, then release to IDLE
    add(1,0,1,0,1, 0,0,0,0,0,0);
    add(1,0,1,0,1, 1,0,0,1,0,0);
    add(1,0,0,0,1, 1,0,0,1,1,1);
    add(1,0,1,0,1, 1,0,0,1,1,0);
    add(1,0,1,0,1, 1,0,0,1,1,1);
    add(0,0,0,0,1, 0,0,0,1,1,1);
    add(0,0,0,0,1, 0,0,0,0,0,1);
    // contention: A was served last, so B wins; 4 B then 4 A then B again
    add(1,1,1,0,1, 0,0,0,0,0,1);
    add(1,1,1,0,1, 0,1,1,1,0,1);
    add(1,1,1,0,1, 0,1,1,1,1,0);
    add(1,1,1,0,1, 0,1,1,1,1,0);
    add(1,1,1,0,1, 0,1,1,1,1,0);
    add(1,1,1,0,1, 1,0,0,1,1,0);
    add(1,1,1,0,1, 1,0,0,1,1,1);
    add(1,1,1,0,1, 1,0,0,1,1,1);
    add(1,1,1,0,1, 1,0,0,1,1,1);
    add(1,1,1,0,1, 0,1,1,1,1,1);
    // release: B drops with A waiting, then A drops with B waiting, then both drop
    add(1,0,1,0,1, 0,0,1,1,1,0);
    add(1,1,0,0,1, 1,0,0,1,0,0);
    add(0,1,0,0,1, 0,0,0,1,1,0);
    add(0,1,0,1,1, 0,1,1,1,0,0);
    add(0,0,0,0,1, 0,0,1,1,1,1);
    add(0,0,0,0,1, 0,0,0,0,0,1);
    // backpressure: one ack, five stalled cycles, then one ack per cycle
    add(1,0,1,0,0, 0,0,0,0,0,1);
    add(1,0,0,0,0, 1,0,0,1,0,1);
    for (int i = 0; i < 5; i++) add(1,0,1,0,0, 0,0,0,1,1,0);
    add(1,0,1,0,1, 1,0,0,1,1,0);
    add(1,0,0,0,1, 1,0,0,1,1,1);
    add(0,0,0,0,1, 0,0,0,1,1,0);
    add(0,0,0,0,1, 0,0,0,0,0,0);

    drive(0,0,0,0,1);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // table-driven vectors, one row per clock
    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1 drive(vecs[i].ra, vecs[i].rb, vecs[i].da, vecs[i].db, vecs[i].rdy);
      @(negedge clk);
      check($sformatf("r%0d ack_a", i),     32'(bus.ack_a),     32'(vecs[i].e_ack_a));
      check($sformatf("r%0d ack_b", i),     32'(bus.ack_b),     32'(vecs[i].e_ack_b));
      check($sformatf("r%0d sel", i),       32'(bus.sel),       32'(vecs[i].e_sel));
      check($sformatf("r%0d busy", i),      32'(bus.busy),      32'(vecs[i].e_busy));
      check($sformatf("r%0d out_valid", i), 32'(bus.out_valid), 32'(vecs[i].e_ov));
      check($sformatf("r%0d out_data", i),  32'(bus.out_data),  32'(vecs[i].e_od));
    end

    // mux truth table under sustained contention; B is granted first since A was last
    for (int k = 0; k <= 18; k++) begin
      @(posedge clk);
      a_bit = 1'(k & 1);
      b_bit = 1'((k >> 1) & 1);
      #1 drive(1, 1, a_bit, b_bit, 1);
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_d = exp_q.pop_front();
        check($sformatf("t5 k%0d out_valid", k), 32'(bus.out_valid), 32'd1);
        check($sformatf("t5 k%0d out_data", k),  32'(bus.out_data),  32'(exp_d));
      end
      if (k == 0) begin
        check("t5 idle ack_a", 32'(bus.ack_a), 32'd0);
        check("t5 idle ack_b", 32'(bus.ack_b), 32'd0);
      end else begin
        exp_c = (((k - 1) / MAX_BURST) % 2) == 0;
        check($sformatf("t5 k%0d ack_b", k), 32'(bus.ack_b), 32'(exp_c));
        check($sformatf("t5 k%0d ack_a", k), 32'(bus.ack_a), 32'(!exp_c));
        check($sformatf("t5 k%0d sel", k),   32'(bus.sel),   32'(exp_c));
        exp_q.push_back((a_bit & ~exp_c) | (exp_c & b_bit));
        seen[{exp_c, b_bit, a_bit}] = 1'b1;
      end
    end
    check("t5 combos covered", 32'(seen), 32'hff);

    // asynchronous reset mid-burst with a word buffered
    @(posedge clk);
    #1;
    exp_d = exp_q.pop_front();
    check("t1 pre busy",      32'(bus.busy),      32'd1);
    check("t1 pre out_valid", 32'(bus.out_valid), 32'd1);
    check("t1 pre out_data",  32'(bus.out_data),  32'(exp_d));
    #1 rst_n = 1'b0;
    #1;
    check("t1 rst ack_a",     32'(bus.ack_a),     32'd0);
    check("t1 rst ack_b",     32'(bus.ack_b),     32'd0);
    check("t1 rst sel",       32'(bus.sel),       32'd0);
    check("t1 rst busy",      32'(bus.busy),      32'd0);
    check("t1 rst out_valid", 32'(bus.out_valid), 32'd0);
    check("t1 rst out_data",  32'(bus.out_data),  32'd0);
    check("t1 rst state",     32'(bus.state),     32'd0);
    check("t1 rst burst_cnt", 32'(bus.burst_cnt), 32'd0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("t1 rel busy",  32'(bus.busy),  32'd0);
    check("t1 rel ack_a", 32'(bus.ack_a), 32'd0);
    @(negedge clk);
    check("t1 first sel",   32'(bus.sel),   32'd0);
    check("t1 first busy",  32'(bus.busy),  32'd1);
    check("t1 first ack_a", 32'(bus.ack_a), 32'd1);
    check("t1 first ack_b", 32'(bus.ack_b), 32'd0);
    check("t1 first state", 32'(bus.state), 32'd1);

    drive(0,0,0,0,1);
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
